// File: rtl/par_bus_master.sv
// Initiator for the strobed parallel bus: accepts one read/write request at a time
// and sequences setup, strobe, hold and read turnaround phases on the pins.
module par_bus_master #(
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned TURN_CYC   = 1
) (
    input  logic              iCLK,
    input  logic              iRESETn,
    input  logic              iREQ_VALID,
    output logic              oREQ_READY,
    input  logic              iREQ_WR,
    input  logic [DATA_W-1:0] iREQ_DATA,
    output logic              oRSP_VALID,
    output logic [DATA_W-1:0] oRSP_DATA,
    output logic              oBUS_WR,
    output logic              oBUS_RD,
    output logic              oBUS_OE,
    output logic [DATA_W-1:0] oBUS_DATA,
    input  logic [DATA_W-1:0] iBUS_DATA,
    output logic              oBUSY
);

    localparam int unsigned MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int unsigned MAX_HT  = (HOLD_CYC > TURN_CYC) ? HOLD_CYC : TURN_CYC;
    localparam int unsigned MAX_CYC = (MAX_SS > MAX_HT) ? MAX_SS : MAX_HT;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        TURN   = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               wr_q;

    logic               accept;
    logic               cur_wr;
    logic               phase_done;
    logic               capture;

    logic               bus_wr_d;
    logic               bus_rd_d;
    logic               bus_oe_d;
    logic               rsp_valid_d;
    logic [DATA_W-1:0]  bus_data_d;
    logic [DATA_W-1:0]  rsp_data_d;

    assign oREQ_READY = (state == IDLE);
    assign oBUSY      = ~oREQ_READY;
    assign accept     = iREQ_VALID && oREQ_READY;
    // Direction for the transaction being started this cycle or already in flight
    assign cur_wr     = accept ? iREQ_WR : wr_q;
    assign phase_done = (cnt == '0);
    assign capture    = (state == STROBE) && phase_done && !wr_q;

    // State register, phase counter and latched direction
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state <= IDLE;
            cnt   <= '0;
            wr_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                wr_q <= iREQ_WR;
            end
        end
    end

    // Next-state and phase timing
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SETUP;
                    cnt_nxt   = CNT_W'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (phase_done) begin
                    state_nxt = STROBE;
                    cnt_nxt   = CNT_W'(STROBE_CYC - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            STROBE: begin
                if (phase_done) begin
                    state_nxt = HOLD;
                    cnt_nxt   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (phase_done) begin
                    if (wr_q) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = TURN;
                        cnt_nxt   = CNT_W'(TURN_CYC - 1);
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            TURN: begin
                if (phase_done) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so pins line up with the phase they belong to
    always_comb begin
        bus_wr_d    = 1'b0;
        bus_rd_d    = 1'b0;
        bus_oe_d    = 1'b0;
        rsp_valid_d = capture;
        bus_data_d  = oBUS_DATA;
        rsp_data_d  = oRSP_DATA;
        if (accept && iREQ_WR) begin
            bus_data_d = iREQ_DATA;
        end
        if (capture) begin
            rsp_data_d = iBUS_DATA;
        end
        if ((state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD)) begin
            bus_oe_d = cur_wr;
        end
        if (state_nxt == STROBE) begin
            bus_wr_d = cur_wr;
            bus_rd_d = ~cur_wr;
        end
    end

    // Registered pin and response outputs
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            oBUS_WR    <= 1'b0;
            oBUS_RD    <= 1'b0;
            oBUS_OE    <= 1'b0;
            oBUS_DATA  <= '0;
            oRSP_VALID <= 1'b0;
            oRSP_DATA  <= '0;
        end else begin
            oBUS_WR    <= bus_wr_d;
            oBUS_RD    <= bus_rd_d;
            oBUS_OE    <= bus_oe_d;
            oBUS_DATA  <= bus_data_d;
            oRSP_VALID <= rsp_valid_d;
            oRSP_DATA  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_par_bus_master.sv
// Bench for par_bus_master: default-timing and all-ones-timing instances, a per-cycle
// waveform model built from the phase lengths, and queues of expected bus/response data.
module tb_par_bus_master;

    localparam int unsigned DW = 10;
    localparam int SETUP_P  [2] = '{2, 1};
    localparam int STROBE_P [2] = '{4, 1};
    localparam int HOLD_P   [2] = '{2, 1};
    localparam int TURN_P   [2] = '{1, 1};

    logic          clk;
    logic          rst_n;
    logic          req_valid [2];
    logic          req_wr    [2];
    logic [DW-1:0] req_data  [2];
    logic [DW-1:0] bus_in    [2];
    logic          req_ready [2];
    logic          rsp_valid [2];
    logic [DW-1:0] rsp_data  [2];
    logic          bus_wr    [2];
    logic          bus_rd    [2];
    logic          bus_oe    [2];
    logic [DW-1:0] bus_data  [2];
    logic          busy      [2];

    int n_cmp;
    int n_err;

    logic [DW-1:0] wq[$];
    logic [DW-1:0] rq[$];
    int            acc_q[$];

    bit            act     [2];
    bit            isw     [2];
    int            k       [2];
    int            gcyc    [2];
    int            rdfall  [2];
    bit            rd_prev [2];
    bit            oe_prev [2];
    logic [DW-1:0] last_rsp[2];

    par_bus_master u_dut_a (
        .iCLK       (clk),
        .iRESETn    (rst_n),
        .iREQ_VALID (req_valid[0]),
        .oREQ_READY (req_ready[0]),
        .iREQ_WR    (req_wr[0]),
        .iREQ_DATA  (req_data[0]),
        .oRSP_VALID (rsp_valid[0]),
        .oRSP_DATA  (rsp_data[0]),
        .oBUS_WR    (bus_wr[0]),
        .oBUS_RD    (bus_rd[0]),
        .oBUS_OE    (bus_oe[0]),
        .oBUS_DATA  (bus_data[0]),
        .iBUS_DATA  (bus_in[0]),
        .oBUSY      (busy[0])
    );

    par_bus_master #(
        .DATA_W     (10),
        .SETUP_CYC  (1),
        .STROBE_CYC (1),
        .HOLD_CYC   (1),
        .TURN_CYC   (1)
    ) u_dut_b (
        .iCLK       (clk),
        .iRESETn    (rst_n),
        .iREQ_VALID (req_valid[1]),
        .oREQ_READY (req_ready[1]),
        .iREQ_WR    (req_wr[1]),
        .iREQ_DATA  (req_data[1]),
        .oRSP_VALID (rsp_valid[1]),
        .oRSP_DATA  (rsp_data[1]),
        .oBUS_WR    (bus_wr[1]),
        .oBUS_RD    (bus_rd[1]),
        .oBUS_OE    (bus_oe[1]),
        .oBUS_DATA  (bus_data[1]),
        .iBUS_DATA  (bus_in[1]),
        .oBUSY      (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {ready, oe, wr, rd, rsp_valid} k cycles after the accept edge
    function automatic logic [4:0] wave(input int u, input bit w, input int kk);
        logic [4:0] v;
        int s;
        int t;
        int h;
        s = SETUP_P[u];
        t = STROBE_P[u];
        h = HOLD_P[u];
        v = 5'b00000;
        if (w) begin
            v[3] = (kk >= 1) && (kk <= s + t + h);
            v[2] = (kk >= s + 1) && (kk <= s + t);
        end else begin
            v[1] = (kk >= s + 1) && (kk <= s + t);
            v[0] = (kk == s + t + 1);
        end
        return v;
    endfunction

    function automatic int done_cyc(input int u, input bit w);
        int d;
        d = SETUP_P[u] + STROBE_P[u] + HOLD_P[u] + 1;
        if (!w) d = d + TURN_P[u];
        return d;
    endfunction

    task automatic mon(input int u);
        logic [4:0] got;
        logic [4:0] exp;
        gcyc[u]++;
        got = {req_ready[u], bus_oe[u], bus_wr[u], bus_rd[u], rsp_valid[u]};
        if (!rst_n) begin
            act[u]      = 1'b0;
            last_rsp[u] = '0;
            rd_prev[u]  = 1'b0;
            oe_prev[u]  = 1'b0;
            rdfall[u]   = -1;
            wq.delete();
            rq.delete();
            chk("reset_outputs", 32'(got), 32'(5'b10000));
            chk("reset_rsp_data", 32'(rsp_data[u]), 32'(0));
            chk("reset_bus_data", 32'(bus_data[u]), 32'(0));
            return;
        end
        if (act[u]) begin
            k[u]++;
            if (k[u] == done_cyc(u, isw[u])) begin
                act[u] = 1'b0;
                if (isw[u] && (wq.size() > 0)) void'(wq.pop_front());
            end
        end
        exp = act[u] ? wave(u, isw[u], k[u]) : 5'b10000;
        chk("bus_timing", 32'(got), 32'(exp));
        chk("busy", 32'(busy[u]), 32'(!exp[4]));
        if (bus_wr[u] || bus_rd[u]) chk("strobe_overlap", 32'(bus_wr[u] && bus_rd[u]), 32'(0));
        if (bus_oe[u]) begin
            chk("write_queue_size", 32'(wq.size()), 32'(1));
            if (wq.size() > 0) chk("write_data", 32'(bus_data[u]), 32'(wq[0]));
        end
        if (rsp_valid[u]) begin
            chk("read_queue_size", 32'(rq.size()), 32'(1));
            if (rq.size() > 0) last_rsp[u] = rq.pop_front();
        end
        chk("rsp_data", 32'(rsp_data[u]), 32'(last_rsp[u]));
        if (rd_prev[u] && !bus_rd[u]) rdfall[u] = gcyc[u];
        if (!oe_prev[u] && bus_oe[u] && (rdfall[u] >= 0))
            chk("turnaround", 32'((gcyc[u] - rdfall[u]) > TURN_P[u]), 32'(1));
        rd_prev[u] = bus_rd[u];
        oe_prev[u] = bus_oe[u];
        if (!act[u] && req_valid[u]) begin
            act[u] = 1'b1;
            isw[u] = req_wr[u];
            k[u]   = 0;
            acc_q.push_back(gcyc[u]);
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Drive one request from posedge+2 and return in the cycle the master is ready again
    task automatic send(input int u, input bit w, input logic [DW-1:0] d,
                        input logic [DW-1:0] bin, input bit junk);
        int n;
        req_valid[u] = 1'b1;
        req_wr[u]    = w;
        req_data[u]  = d;
        if (!w) bus_in[u] = bin;
        n = 0;
        @(negedge clk);
        while (!req_ready[u] && (n < 200)) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready[u]) begin
            chk("accept_timeout", 32'(req_ready[u]), 32'(1));
            return;
        end
        if (w) wq.push_back(d);
        else rq.push_back(bin);
        @(posedge clk);
        #2;
        n = 1;
        while (!req_ready[u] && (n < 200)) begin
            if (!w && (n == SETUP_P[u] + STROBE_P[u] + 1)) bus_in[u] = 10'h3FF;
            if (junk) begin
                req_wr[u]   = 1'($urandom);
                req_data[u] = DW'($urandom);
            end
            @(posedge clk);
            #2;
            n++;
        end
        if (!req_ready[u]) chk("ready_timeout", 32'(req_ready[u]), 32'(1));
    endtask

    task automatic drop(input int u);
        req_valid[u] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_wr[i]    = 1'b0;
            req_data[i]  = '0;
            bus_in[i]    = '0;
            rdfall[i]    = -1;
        end
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(1);

        // Single write, then single read with data changing after capture
        send(0, 1'b1, 10'h2A5, 10'h000, 1'b0);
        drop(0);
        idle(2);
        send(0, 1'b0, 10'h000, 10'h15C, 1'b0);
        drop(0);
        idle(2);

        // Back-to-back write, read, write with valid held high
        acc_q.delete();
        send(0, 1'b1, 10'h0F0, 10'h000, 1'b0);
        send(0, 1'b0, 10'h000, 10'h2C3, 1'b0);
        send(0, 1'b1, 10'h30F, 10'h000, 1'b0);
        drop(0);
        chk("accept_count_a", 32'(acc_q.size()), 32'(3));
        if (acc_q.size() == 3) begin
            chk("accept_gap_wr_rd", 32'(acc_q[1] - acc_q[0]), 32'(9));
            chk("accept_gap_wr_rd_wr", 32'(acc_q[2] - acc_q[0]), 32'(19));
        end
        idle(1);

        // Requests churned while busy must not disturb the latched transfer
        send(0, 1'b1, 10'h155, 10'h000, 1'b1);
        send(0, 1'b0, 10'h000, 10'h0AA, 1'b1);
        send(0, 1'b1, 10'h2D2, 10'h000, 1'b1);
        drop(0);
        idle(2);

        // Reset in the middle of a read strobe
        req_valid[0] = 1'b1;
        req_wr[0]    = 1'b0;
        bus_in[0]    = 10'h0C7;
        @(negedge clk);
        if (req_ready[0]) rq.push_back(10'h0C7);
        @(posedge clk);
        #2;
        drop(0);
        idle(3);
        chk("rd_before_reset", 32'(bus_rd[0]), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("async_reset_pins", 32'({bus_oe[0], bus_wr[0], bus_rd[0], rsp_valid[0]}), 32'(0));
        idle(3);
        rst_n = 1'b1;
        idle(1);
        send(0, 1'b1, 10'h3C3, 10'h000, 1'b0);
        drop(0);
        idle(2);

        // Minimum-timing instance: single transfers then back-to-back
        send(1, 1'b1, 10'h1E1, 10'h000, 1'b0);
        drop(1);
        idle(2);
        send(1, 1'b0, 10'h000, 10'h234, 1'b0);
        drop(1);
        idle(2);
        acc_q.delete();
        send(1, 1'b1, 10'h011, 10'h000, 1'b0);
        send(1, 1'b0, 10'h000, 10'h3A1, 1'b0);
        send(1, 1'b1, 10'h222, 10'h000, 1'b1);
        drop(1);
        chk("accept_count_b", 32'(acc_q.size()), 32'(3));
        if (acc_q.size() == 3) begin
            chk("accept_gap_b1", 32'(acc_q[1] - acc_q[0]), 32'(4));
            chk("accept_gap_b2", 32'(acc_q[2] - acc_q[0]), 32'(9));
        end
        idle(3);

        chk("write_queue_drained", 32'(wq.size()), 32'(0));
        chk("read_queue_drained", 32'(rq.size()), 32'(0));
        chk("final_rsp_a", 32'(rsp_data[0]), 32'(0));
        chk("final_rsp_b", 32'(rsp_data[1]), 32'(10'h3A1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
